// File: rtl/decode_stage.sv
// Instruction decode stage: register file with writeback bypass, opcode/funct
// decode and a single ID/EX output register feeding execute.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] da,
    output logic [31:0] db,
    output logic [15:0] imm16,
    output logic [2:0]  ALUCntrl,
    output logic        ALUSrc,
    output logic [4:0]  dest,
    output logic        RegWr,
    output logic        MemWr,
    output logic        MemToReg,
    output logic        Branch,
    output logic        Jump,
    output logic        JumpReg,
    output logic        Link,
    output logic        illegal,
    output logic        out_valid
);

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluXor = 3'b010;
    localparam logic [2:0] AluSlt = 3'b011;

    // Control bundle order: RegWr, MemWr, MemToReg, Branch, Jump, JumpReg, Link, illegal
    logic [31:0] regs [32];
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op, funct;
    logic [31:0] rd_a, rd_b;
    logic        wr_hit;

    logic [2:0]  dec_alu;
    logic        dec_src;
    logic [4:0]  dec_dest;
    logic [7:0]  dec_ctrl;

    logic [31:0] da_q, da_d, db_q, db_d;
    logic [15:0] imm_q, imm_d;
    logic [2:0]  alu_q, alu_d;
    logic        src_q, src_d;
    logic [4:0]  dest_q, dest_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        valid_q, valid_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign wr_hit = wr_en && (wr_addr != 5'd0);

    // Register file; r0 is never written so it always reads 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand read with same-cycle writeback bypass
    always_comb begin
        rd_a = (wr_hit && wr_addr == rs) ? wr_data : regs[rs];
        rd_b = (wr_hit && wr_addr == rt) ? wr_data : regs[rt];
    end

    // Opcode/funct decode
    always_comb begin
        dec_alu  = AluAdd;
        dec_src  = 1'b0;
        dec_dest = 5'd0;
        dec_ctrl = 8'd0;
        unique case (op)
            6'h00: begin
                unique case (funct)
                    6'h20: begin dec_ctrl[7] = 1'b1; dec_dest = rd; end
                    6'h22: begin dec_alu = AluSub; dec_ctrl[7] = 1'b1; dec_dest = rd; end
                    6'h2A: begin dec_alu = AluSlt; dec_ctrl[7] = 1'b1; dec_dest = rd; end
                    6'h08: dec_ctrl[2] = 1'b1;
                    default: dec_ctrl[0] = 1'b1;
                endcase
            end
            6'h08: begin dec_src = 1'b1; dec_ctrl[7] = 1'b1; dec_dest = rt; end
            6'h0E: begin dec_alu = AluXor; dec_src = 1'b1; dec_ctrl[7] = 1'b1; dec_dest = rt; end
            6'h23: begin
                dec_src     = 1'b1;
                dec_ctrl[7] = 1'b1;
                dec_ctrl[5] = 1'b1;
                dec_dest    = rt;
            end
            6'h2B: begin dec_src = 1'b1; dec_ctrl[6] = 1'b1; end
            6'h05: begin dec_alu = AluSub; dec_ctrl[4] = 1'b1; end
            6'h02: dec_ctrl[3] = 1'b1;
            6'h03: begin
                dec_ctrl[3] = 1'b1;
                dec_ctrl[1] = 1'b1;
                dec_ctrl[7] = 1'b1;
                dec_dest    = 5'd31;
            end
            default: dec_ctrl[0] = 1'b1;
        endcase
    end

    // ID/EX next state: flush > stall > load; bubbles zero every field
    always_comb begin
        da_d    = 32'd0;
        db_d    = 32'd0;
        imm_d   = 16'd0;
        alu_d   = AluAdd;
        src_d   = 1'b0;
        dest_d  = 5'd0;
        ctrl_d  = 8'd0;
        valid_d = 1'b0;
        rs_d    = 5'd0;
        rt_d    = 5'd0;
        if (flush) begin
            // bubble (defaults)
        end else if (stall) begin
            da_d    = (wr_hit && wr_addr == rs_q) ? wr_data : da_q;
            db_d    = (wr_hit && wr_addr == rt_q) ? wr_data : db_q;
            imm_d   = imm_q;
            alu_d   = alu_q;
            src_d   = src_q;
            dest_d  = dest_q;
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
            rs_d    = rs_q;
            rt_d    = rt_q;
        end else if (in_valid) begin
            da_d    = rd_a;
            db_d    = rd_b;
            imm_d   = instr[15:0];
            alu_d   = dec_alu;
            src_d   = dec_src;
            dest_d  = dec_dest;
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            rs_d    = rs;
            rt_d    = rt;
        end
    end

    // ID/EX output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            da_q    <= 32'd0;
            db_q    <= 32'd0;
            imm_q   <= 16'd0;
            alu_q   <= AluAdd;
            src_q   <= 1'b0;
            dest_q  <= 5'd0;
            ctrl_q  <= 8'd0;
            valid_q <= 1'b0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
        end else begin
            da_q    <= da_d;
            db_q    <= db_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    assign da        = da_q;
    assign db        = db_q;
    assign imm16     = imm_q;
    assign ALUCntrl  = alu_q;
    assign ALUSrc    = src_q;
    assign dest      = dest_q;
    assign RegWr     = ctrl_q[7];
    assign MemWr     = ctrl_q[6];
    assign MemToReg  = ctrl_q[5];
    assign Branch    = ctrl_q[4];
    assign Jump      = ctrl_q[3];
    assign JumpReg   = ctrl_q[2];
    assign Link      = ctrl_q[1];
    assign illegal   = ctrl_q[0];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage plus hand-written reset and stall sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        in_valid, stall, flush, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] da, db;
    logic [15:0] imm16;
    logic [2:0]  ALUCntrl;
    logic        ALUSrc;
    logic [4:0]  dest;
    logic        RegWr, MemWr, MemToReg, Branch, Jump, JumpReg, Link, illegal, out_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .stall(stall),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .da(da), .db(db), .imm16(imm16), .ALUCntrl(ALUCntrl), .ALUSrc(ALUSrc),
        .dest(dest), .RegWr(RegWr), .MemWr(MemWr), .MemToReg(MemToReg), .Branch(Branch),
        .Jump(Jump), .JumpReg(JumpReg), .Link(Link), .illegal(illegal),
        .out_valid(out_valid)
    );

    // ctrl order: RegWr MemWr MemToReg Branch Jump JumpReg Link illegal out_valid
    localparam logic [8:0] C_BUB = 9'b000000000;
    localparam logic [8:0] C_ALU = 9'b100000001;
    localparam logic [8:0] C_LW  = 9'b101000001;
    localparam logic [8:0] C_SW  = 9'b010000001;
    localparam logic [8:0] C_BNE = 9'b000100001;
    localparam logic [8:0] C_J   = 9'b000010001;
    localparam logic [8:0] C_JAL = 9'b100010101;
    localparam logic [8:0] C_JR  = 9'b000001001;
    localparam logic [8:0] C_ILL = 9'b000000011;

    typedef struct packed {
        logic [31:0] da;
        logic [31:0] db;
        logic [15:0] imm;
        logic [2:0]  alu;
        logic        src;
        logic [4:0]  dest;
        logic [8:0]  ctrl;
        logic        chk_data;
    } exp_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [31:0] instr;
        logic        in_valid;
        logic        stall;
        logic        flush;
        exp_t        e;
    } vec_t;

    function automatic exp_t ex(input logic [31:0] a, input logic [31:0] b,
                                input logic [15:0] imm, input logic [2:0] alu,
                                input logic src, input logic [4:0] d,
                                input logic [8:0] c, input logic chk);
        exp_t r;
        r.da = a; r.db = b; r.imm = imm; r.alu = alu; r.src = src;
        r.dest = d; r.ctrl = c; r.chk_data = chk;
        return r;
    endfunction

    function automatic vec_t mv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] ins, input logic iv, input logic st,
                                input logic fl, input exp_t e);
        vec_t r;
        r.wr_en = we; r.wr_addr = wa; r.wr_data = wd; r.instr = ins;
        r.in_valid = iv; r.stall = st; r.flush = fl; r.e = e;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
        instr = v.instr; in_valid = v.in_valid; stall = v.stall; flush = v.flush;
    endtask

    task automatic check(input string name, input exp_t e);
        logic [97:0] act, req;
        act = {da, db, imm16, ALUCntrl, ALUSrc, dest,
               RegWr, MemWr, MemToReg, Branch, Jump, JumpReg, Link, illegal, out_valid};
        req = {e.da, e.db, e.imm, e.alu, e.src, e.dest, e.ctrl};
        if (!e.chk_data) begin
            act[97:18] = '0;
            req[97:18] = '0;
        end
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got da=%h db=%h imm=%h alu=%b src=%b dest=%0d ctrl=%b, want da=%h db=%h imm=%h alu=%b src=%b dest=%0d ctrl=%b",
                     name, act[97:66], act[65:34], act[33:18], act[17:15], act[14],
                     act[13:9], act[8:0], req[97:66], req[65:34], req[33:18], req[17:15],
                     req[14], req[13:9], req[8:0]);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.e);
    endtask

    vec_t vecs [20];
    exp_t zero_e, lw_e;

    initial begin
        zero_e = ex(32'd0, 32'd0, 16'd0, 3'b000, 1'b0, 5'd0, C_BUB, 1'b1);

        vecs[0]  = mv(1, 5'd1, 32'd5, 32'h0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, C_BUB, 0));
        vecs[1]  = mv(1, 5'd2, 32'd7, 32'h0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, C_BUB, 0));
        vecs[2]  = mv(0, 5'd0, 32'd0, 32'h00221820, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h1820, 3'b000, 0, 5'd3, C_ALU, 1));
        vecs[3]  = mv(1, 5'd4, 32'hDEADBEEF, 32'h2085FFFF, 1, 0, 0,
                      ex(32'hDEADBEEF, 32'd0, 16'hFFFF, 3'b000, 1, 5'd5, C_ALU, 1));
        vecs[4]  = mv(1, 5'd0, 32'h1234, 32'h0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, C_BUB, 0));
        vecs[5]  = mv(1, 5'd0, 32'h55, 32'h00004020, 1, 0, 0,
                      ex(32'd0, 32'd0, 16'h4020, 3'b000, 0, 5'd8, C_ALU, 1));
        vecs[6]  = mv(0, 5'd0, 32'd0, 32'h14220003, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h0003, 3'b001, 0, 5'd0, C_BNE, 1));
        vecs[7]  = mv(0, 5'd0, 32'd0, 32'h08000010, 1, 0, 0,
                      ex(32'd0, 32'd0, 16'h0010, 3'b000, 0, 5'd0, C_J, 1));
        vecs[8]  = mv(0, 5'd0, 32'd0, 32'h0C000020, 1, 0, 0,
                      ex(32'd0, 32'd0, 16'h0020, 3'b000, 0, 5'd31, C_JAL, 1));
        vecs[9]  = mv(0, 5'd0, 32'd0, 32'h00800008, 1, 0, 0,
                      ex(32'hDEADBEEF, 32'd0, 16'h0008, 3'b000, 0, 5'd0, C_JR, 1));
        vecs[10] = mv(0, 5'd0, 32'd0, 32'h384900FF, 1, 0, 0,
                      ex(32'd7, 32'd0, 16'h00FF, 3'b010, 1, 5'd9, C_ALU, 1));
        vecs[11] = mv(0, 5'd0, 32'd0, 32'hFC000000, 1, 0, 0,
                      ex(32'd0, 32'd0, 16'h0000, 3'b000, 0, 5'd0, C_ILL, 1));
        vecs[12] = mv(0, 5'd0, 32'd0, 32'h0022183F, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h183F, 3'b000, 0, 5'd0, C_ILL, 1));
        vecs[13] = mv(0, 5'd0, 32'd0, 32'h00221822, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h1822, 3'b001, 0, 5'd3, C_ALU, 1));
        vecs[14] = mv(0, 5'd0, 32'd0, 32'h0022182A, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h182A, 3'b011, 0, 5'd3, C_ALU, 1));
        vecs[15] = mv(0, 5'd0, 32'd0, 32'hAC220004, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h0004, 3'b000, 1, 5'd0, C_SW, 1));
        vecs[16] = mv(0, 5'd0, 32'd0, 32'h00221820, 1, 1, 0,
                      ex(32'd5, 32'd7, 16'h0004, 3'b000, 1, 5'd0, C_SW, 1));
        vecs[17] = mv(0, 5'd0, 32'd0, 32'hAC220004, 1, 1, 1,
                      ex(0, 0, 0, 0, 0, 0, C_BUB, 0));
        vecs[18] = mv(0, 5'd0, 32'd0, 32'hAC220004, 1, 0, 0,
                      ex(32'd5, 32'd7, 16'h0004, 3'b000, 1, 5'd0, C_SW, 1));
        vecs[19] = mv(0, 5'd0, 32'd0, 32'h0, 0, 1, 0,
                      ex(32'd5, 32'd7, 16'h0004, 3'b000, 1, 5'd0, C_SW, 1));

        // Reset with random inputs
        reset = 1'b1;
        instr = $urandom; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("reset", zero_e);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Stall refresh: held LW sees writes to its rs/rt
        lw_e = ex(32'd0, 32'd0, 16'h0008, 3'b000, 1, 5'd6, C_LW, 1);
        step("lw_load", mv(0, 5'd0, 32'd0, 32'h8CE60008, 1, 0, 0, lw_e));
        step("stall1", mv(0, 5'd0, 32'd0, 32'h00221820, 1, 1, 0, lw_e));
        lw_e.da = 32'h100;
        step("stall2_wr_rs", mv(1, 5'd7, 32'h100, 32'h00221820, 1, 1, 0, lw_e));
        lw_e.db = 32'h77;
        step("stall3_wr_rt", mv(1, 5'd6, 32'h77, 32'h0, 0, 1, 0, lw_e));
        step("stall_release", mv(0, 5'd0, 32'd0, 32'h0, 0, 0, 0,
                                 ex(0, 0, 0, 0, 0, 0, C_BUB, 0)));

        // Load a valid instruction, then async reset mid-cycle together with a write
        step("pre_reset", vecs[2]);
        #2;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA; reset = 1'b1;
        #1;
        check("async_reset", zero_e);
        @(posedge clk);
        #1;
        check("reset_hold", zero_e);
        reset = 1'b0;
        // r10 write was lost; r1 was cleared by reset
        step("post_reset_add", mv(0, 5'd0, 32'd0, 32'h01415820, 1, 0, 0,
                                  ex(32'd0, 32'd0, 16'h5820, 3'b000, 0, 5'd11, C_ALU, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage for the single-issue 32-bit CPU; it produces the operands and control that feed the execute stage. It latches a 32-bit instruction, reads the 32×32 register file and decodes opcode/funct. It registers da, db, imm16, ALUCntrl, ALUSrc and downstream write/branch controls into one ID/EX output stage. The same block owns the register-file write port driven by writeback, with same-cycle write-to-read bypass.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register address, 3-bit ALU control).
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr  in  32  instruction word from fetch
- in_valid  in  1  instr is valid this cycle
- stall  in  1  hold ID/EX outputs unchanged
- flush  in  1  replace next ID/EX contents with a bubble
- wr_en  in  1  writeback register write enable
- wr_addr  in  5  writeback destination register
- wr_data  in  32  writeback data
- da  out  32  rs operand
- db  out  32  rt operand
- imm16  out  16  instr[15:0], raw (execute sign-extends)
- ALUCntrl  out  3  ADD=000, SUB=001, XOR=010, SLT=011, AND=100, NAND=101, NOR=110, OR=111
- ALUSrc  out  1  1 = immediate is second ALU operand, 0 = db
- dest  out  5  destination register for writeback
- RegWr, MemWr, MemToReg, Branch, Jump, JumpReg, Link  out  1 each  downstream controls
- illegal  out  1  unsupported opcode/funct
- out_valid  out  1  ID/EX contents are a real instruction

## Operation
- Register file: 32×32. Register 0 always reads 0; writes to it are ignored. On wr_en at the edge, regs[wr_addr] <= wr_data.
- Read bypass: if wr_en && wr_addr == rs (or rt) && wr_addr != 0 in the capture cycle, da (or db) captures wr_data, not the stale array value.
- Decode (rs=instr[25:21], rt=[20:16], rd=[15:11], op=[31:26], funct=[5:0]):
  - R-type op 0x00:
    - funct 0x20 ADD, 0x22 SUB, 0x2A SLT: ALUSrc=0, RegWr=1, dest=rd.
    - funct 0x08 JR: JumpReg=1, RegWr=0.
  - 0x08 ADDI: ADD, ALUSrc=1, RegWr=1, dest=rt.
  - 0x0E XORI: XOR, ALUSrc=1, RegWr=1, dest=rt.
  - 0x23 LW: ADD, ALUSrc=1, RegWr=1, MemToReg=1, dest=rt.
  - 0x2B SW: ADD, ALUSrc=1, MemWr=1.
  - 0x05 BNE: SUB, ALUSrc=0, Branch=1.
  - 0x02 J: Jump=1.
  - 0x03 JAL: Jump=1, Link=1, RegWr=1, dest=31.
  - Anything else: illegal=1; RegWr, MemWr, Branch, Jump, JumpReg and Link all 0.
- Unlisted controls default to 0, ALUCntrl to ADD and dest to 0.
- Bubble: out_valid=0 and every control output 0. da, db and imm16 are don't-care but must still be deterministic.

## Timing
- Reset (async, immediate): all outputs 0, out_valid=0, all 32 registers 0.
- Latency 1 cycle: instr with in_valid sampled at edge N appears on the outputs after edge N.
- Per-edge priority is flush > stall > load:
  - flush: bubble loaded, regardless of stall or in_valid.
  - stall: all outputs hold, with one exception. If wr_en targets the held rs/rt (nonzero), the held da/db update to wr_data, so a stalled instruction sees writeback.
  - Otherwise, in_valid=0 loads a bubble and in_valid=1 loads the decoded instruction.
- Register-file writes occur every edge with wr_en, independent of stall and flush.
- wr_en and reset asserted together: reset wins; the write is lost.
- Reset deassertion mid-stream: first capture at the first edge after release.

## Test plan
- Reset:
  - Stimulus: assert reset with random inputs.
  - Required: all outputs 0; reading any register afterwards returns 0.
- Write then ADD:
  - Stimulus: write r1=5, r2=7; next cycle issue ADD r3,r1,r2 (0x00221820).
  - Required: da=5, db=7, ALUCntrl=000, ALUSrc=0, RegWr=1, dest=3, out_valid=1.
- Bypass:
  - Stimulus: in the same cycle, wr_en r4=0xDEADBEEF and issue ADDI r5,r4,-1 (0x2085FFFF).
  - Required: da=0xDEADBEEF, imm16=0xFFFF, ALUSrc=1, dest=5.
  - Also: a write to r0 then a read of r0 gives 0.
- Stall refresh:
  - Stimulus: capture LW r6,8(r7) (0x8CE60008), hold stall 3 cycles, write r7=0x100 during the stall.
  - Required: outputs frozen except da becomes 0x100; MemToReg=1 throughout.
- Flush priority:
  - Stimulus: assert flush and stall together with a valid SW.
  - Required: out_valid=0, MemWr=0 at the next edge.
- Decode coverage:
  - Stimulus: issue BNE, J, JAL, JR, XORI and opcode 0x3F.
  - Required: BNE gives Branch=1, ALUCntrl=001. JAL gives dest=31, Link=1. Opcode 0x3F gives illegal=1 with RegWr=0 and MemWr=0.
